// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared widths, opcode and FSM state encodings for the fcpu core
package fcpu_pkg;
  localparam int DATA_W = 32;
  localparam int CRAM_ADDR_W = 10;
  localparam int DRAM_ADDR_W = 10;
  typedef enum logic [5:0] {
    I_NOP    = 6'h00,
    I_SETI1  = 6'h01,
    I_SETI2  = 6'h02,
    I_ADD    = 6'h03,
    I_SUB    = 6'h04,
    I_AND    = 6'h05,
    I_OR     = 6'h06,
    I_LOADR  = 6'h08,
    I_STORER = 6'h09,
    I_JMP    = 6'h0A,
    I_BEQ    = 6'h0B,
    I_GETC   = 6'h0C,
    I_PUTC   = 6'h0D,
    I_HALT   = 6'h3F
  } op_e;
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_LOAD, S_IN, S_OUT, S_HALT} state_e;
endpackage

// File: rtl/fcpu_if.sv
// fcpu_if: code RAM port (cram_addr/cram_data) and byte streams (io_o_*, io_i_*); master = core, slave = environment
interface fcpu_if;
  import fcpu_pkg::*;
  logic [CRAM_ADDR_W-1:0] cram_addr;
  logic [DATA_W-1:0]      cram_data;
  logic [7:0]             io_o_data;
  logic                   io_o_valid;
  logic                   io_o_ready;
  logic [7:0]             io_i_data;
  logic                   io_i_valid;
  logic                   io_i_ready;
  modport master (
    output cram_addr, io_o_data, io_o_valid, io_i_ready,
    input  cram_data, io_o_ready, io_i_data, io_i_valid
  );
  modport slave (
    input  cram_addr, io_o_data, io_o_valid, io_i_ready,
    output cram_data, io_o_ready, io_i_data, io_i_valid
  );
endinterface

// File: rtl/fcpu_regfile.sv
// fcpu_regfile: 32x32 registers; ports clk/rst, two combinational reads (raddr0/1 -> rdata0/1), one sync write (we/waddr/wdata), r0 reads 0
module fcpu_regfile
  import fcpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        raddr0,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] rf_q [32];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    else if (we && waddr != 5'd0) rf_q[waddr] <= wdata;
  assign rdata0 = raddr0 == 5'd0 ? '0 : rf_q[raddr0];
  assign rdata1 = raddr1 == 5'd0 ? '0 : rf_q[raddr1];
endmodule

// File: rtl/fcpu_core.sv
// fcpu_core: multi-cycle load/store core; ports clk, nrst (sync active-high reset), io (fcpu_if.master: code RAM + byte streams)
module fcpu_core
  import fcpu_pkg::*;
(
  input  logic   clk,
  input  logic   nrst,
  fcpu_if.master io
);
  state_e                 state_q, state_d;
  logic [CRAM_ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [7:0]             out_q, out_d;
  logic [4:0]             a_q, a_d;
  logic                   st_pend_q, st_pend_d;
  logic [DRAM_ADDR_W-1:0] st_addr_q, st_addr_d;
  logic [DATA_W-1:0]      dram_mem [2**DRAM_ADDR_W];
  logic [DATA_W-1:0]      dram_q;
  logic [5:0]             op;
  logic [4:0]             f_a, f_b, f_c, ra_x, wa;
  logic [DATA_W-1:0]      rd_b, rd_x, sum, wd;
  logic [DRAM_ADDR_W-1:0] addr;
  logic                   we;
  assign op = io.cram_data[31:26];
  assign f_a = io.cram_data[25:21];
  assign f_b = io.cram_data[20:16];
  assign f_c = io.cram_data[15:11];
  assign pc_inc = pc_q + CRAM_ADDR_W'(1);
  // Only two read ports: STORER latches its address in EXEC and reads R[a] in the following FETCH,
  // where the ports are otherwise idle; the write still lands before the next instruction executes.
  assign ra_x = state_q == S_FETCH ? a_q
              : (op == I_BEQ || op == I_PUTC || op == I_SETI1) ? f_a : f_c;
  assign wa = state_q == S_EXEC ? f_a : a_q;
  assign sum = rd_b + rd_x;
  assign addr = sum[DRAM_ADDR_W-1:0];
  fcpu_regfile u_rf (
    .clk(clk), .rst(nrst),
    .raddr0(f_b), .raddr1(ra_x), .rdata0(rd_b), .rdata1(rd_x),
    .we(we), .waddr(wa), .wdata(wd)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    out_d = out_q;
    a_d = a_q;
    st_pend_d = 1'b0;
    st_addr_d = st_addr_q;
    we = 1'b0;
    wd = dram_q;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        a_d = f_a;
        pc_d = pc_inc;
        state_d = S_FETCH;
        case (op)
          I_SETI1: begin we = 1'b1; wd = {io.cram_data[10:0], rd_x[20:0]}; end
          I_SETI2: begin we = 1'b1; wd = {11'b0, io.cram_data[20:0]}; end
          I_ADD: begin we = 1'b1; wd = sum; end
          I_SUB: begin we = 1'b1; wd = rd_b - rd_x; end
          I_AND: begin we = 1'b1; wd = rd_b & rd_x; end
          I_OR: begin we = 1'b1; wd = rd_b | rd_x; end
          I_LOADR: state_d = S_LOAD;
          I_STORER: begin st_pend_d = 1'b1; st_addr_d = addr; end
          I_JMP: pc_d = io.cram_data[CRAM_ADDR_W-1:0];
          I_BEQ: pc_d = rd_b == rd_x ? pc_inc + io.cram_data[CRAM_ADDR_W-1:0] : pc_inc;
          I_GETC: state_d = S_IN;
          I_PUTC: begin out_d = rd_x[7:0]; state_d = S_OUT; end
          I_HALT: begin pc_d = pc_q; state_d = S_HALT; end
          default: ;
        endcase
      end
      S_LOAD: begin we = 1'b1; state_d = S_FETCH; end
      S_IN: if (io.io_i_valid) begin we = 1'b1; wd = {24'b0, io.io_i_data}; state_d = S_FETCH; end
      S_OUT: state_d = io.io_o_ready ? S_FETCH : S_OUT;
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (nrst) begin
      state_q <= S_FETCH;
      pc_q <= '0;
      out_q <= '0;
      a_q <= '0;
      st_pend_q <= 1'b0;
      st_addr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_q <= out_d;
      a_q <= a_d;
      st_pend_q <= st_pend_d;
      st_addr_q <= st_addr_d;
    end
  always_ff @(posedge clk) begin
    if (!nrst && st_pend_q) dram_mem[st_addr_q] <= rd_x;
    dram_q <= dram_mem[addr];
  end
  assign io.cram_addr = pc_q;
  assign io.io_o_data = out_q;
  assign io.io_o_valid = state_q == S_OUT;
  assign io.io_i_ready = state_q == S_IN;
endmodule

// File: tb/tb_fcpu_core.sv
// tb_fcpu_core: directed and random programs checked against an instruction-level model of the core
module tb_fcpu_core;
  import fcpu_pkg::*;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  fcpu_if bus();
  fcpu_core dut (.clk(clk), .nrst(nrst), .io(bus));
  always #5 clk = ~clk;
  logic [31:0] cram [1024];
  always @(posedge clk) bus.cram_data <= cram[bus.cram_addr];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_r [32];
  logic [31:0] m_dram [1024];
  logic [9:0] m_pc;
  logic [7:0] m_out;
  int hold = -1;
  logic [7:0] in_byte = 8'h00;
  bit h;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc(logic [5:0] op, int a, int b, int c);
    return {op, 5'(a), 5'(b), 5'(c), 11'b0};
  endfunction
  function automatic logic [31:0] enci(logic [5:0] op, int a, int imm);
    return {op, 5'(a), 21'(imm)};
  endfunction
  function automatic logic [31:0] encb(int a, int b, int off);
    return {I_BEQ, 5'(a), 5'(b), 16'(off)};
  endfunction
  function automatic logic [31:0] encj(int t);
    return {I_JMP, 26'(t)};
  endfunction
  function automatic logic [31:0] rand_ins();
    int sel = $urandom_range(0, 15);
    int a = $urandom_range(0, 7);
    int b = $urandom_range(0, 7);
    int c = $urandom_range(0, 7);
    case (sel)
      0: return {6'h00, 26'($urandom)};
      1: return enci(I_SETI1, a, int'($urandom));
      2, 3: return enci(I_SETI2, a, int'($urandom));
      4: return enc(I_ADD, a, b, c);
      5: return enc(I_SUB, a, b, c);
      6: return enc(I_AND, a, b, c);
      7: return enc(I_OR, a, b, c);
      8: return enc(I_LOADR, a, b, c);
      9: return enc(I_STORER, a, b, c);
      10: return {I_JMP, 16'($urandom), 10'($urandom_range(0, 47))};
      11: return encb(a, b, $urandom_range(0, 12) - 6);
      12: return enc(I_GETC, a, 0, 0);
      13: return enc(I_PUTC, a, 0, 0);
      14: return {6'h07, 26'($urandom)};
      default: return {6'($urandom_range(14, 62)), 26'($urandom)};
    endcase
  endfunction
  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    if (a != 5'd0) m_r[a] = v;
  endtask
  task automatic noise();
    bus.io_o_ready = 1'($urandom);
    bus.io_i_valid = 1'($urandom);
    bus.io_i_data = 8'($urandom);
  endtask
  task automatic step(output bit halted);
    logic [31:0] ins, ra, rb, rc, s;
    logic [4:0] a;
    logic [9:0] npc;
    int k;
    halted = 1'b0;
    chk("pc", 32'(bus.cram_addr), 32'(m_pc));
    chk("o_valid_idle", 32'(bus.io_o_valid), 0);
    chk("i_ready_idle", 32'(bus.io_i_ready), 0);
    chk("o_data_held", 32'(bus.io_o_data), 32'(m_out));
    ins = cram[m_pc];
    a = ins[25:21];
    ra = m_r[a];
    rb = m_r[ins[20:16]];
    rc = m_r[ins[15:11]];
    s = rb + rc;
    npc = m_pc + 10'd1;
    noise();
    @(negedge clk);
    noise();
    @(negedge clk);
    case (ins[31:26])
      I_SETI1: wr(a, {ins[10:0], ra[20:0]});
      I_SETI2: wr(a, {11'b0, ins[20:0]});
      I_ADD: wr(a, rb + rc);
      I_SUB: wr(a, rb - rc);
      I_AND: wr(a, rb & rc);
      I_OR: wr(a, rb | rc);
      I_LOADR: begin wr(a, m_dram[s[9:0]]); @(negedge clk); end
      I_STORER: m_dram[s[9:0]] = ra;
      I_JMP: npc = ins[9:0];
      I_BEQ: if (ra == rb) npc = m_pc + 10'd1 + ins[9:0];
      I_GETC: begin
        k = hold >= 0 ? hold : $urandom_range(0, 3);
        bus.io_i_valid = 1'b0;
        repeat (k) begin
          chk("i_ready_wait", 32'(bus.io_i_ready), 1);
          @(negedge clk);
        end
        bus.io_i_valid = 1'b1;
        bus.io_i_data = in_byte;
        chk("i_ready", 32'(bus.io_i_ready), 1);
        @(negedge clk);
        wr(a, {24'b0, in_byte});
        noise();
      end
      I_PUTC: begin
        m_out = ra[7:0];
        k = hold >= 0 ? hold : $urandom_range(0, 3);
        bus.io_o_ready = 1'b0;
        repeat (k) begin
          chk("o_valid_wait", 32'(bus.io_o_valid), 1);
          chk("o_data_wait", 32'(bus.io_o_data), 32'(m_out));
          @(negedge clk);
        end
        bus.io_o_ready = 1'b1;
        chk("o_valid", 32'(bus.io_o_valid), 1);
        chk("o_data", 32'(bus.io_o_data), 32'(m_out));
        @(negedge clk);
        noise();
      end
      I_HALT: begin halted = 1'b1; npc = m_pc; end
      default: ;
    endcase
    m_pc = npc;
  endtask
  task automatic do_reset();
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_cram_addr", 32'(bus.cram_addr), 0);
    chk("rst_o_valid", 32'(bus.io_o_valid), 0);
    chk("rst_o_data", 32'(bus.io_o_data), 0);
    chk("rst_i_ready", 32'(bus.io_i_ready), 0);
    nrst = 1'b0;
    m_pc = '0;
    m_out = '0;
    foreach (m_r[i]) m_r[i] = '0;
  endtask
  task automatic run(input int max);
    bit hh = 1'b0;
    int n = 0;
    while (!hh && n < max) begin
      step(hh);
      n++;
    end
    chk("halt_reached", 32'(hh), 1);
  endtask
  task automatic check_state(input string tag);
    @(negedge clk);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), dut.u_rf.rf_q[i], m_r[i]);
    for (int i = 0; i < 1024; i++) chk({tag, "_dram"}, dut.dram_mem[i], m_dram[i]);
  endtask
  task automatic clear_cram();
    foreach (cram[i]) cram[i] = '0;
  endtask
  initial begin
    bus.io_o_ready = 1'b0;
    bus.io_i_valid = 1'b0;
    bus.io_i_data = 8'h00;
    foreach (m_dram[i]) m_dram[i] = '0;
    clear_cram();
    cram[0] = enci(I_SETI2, 2, 1);
    cram[1] = enci(I_SETI2, 3, 1024);
    cram[2] = enc(I_STORER, 0, 1, 0);
    cram[3] = enc(I_ADD, 1, 1, 2);
    cram[4] = encb(1, 3, 1);
    cram[5] = encj(2);
    cram[6] = {I_HALT, 26'b0};
    do_reset();
    run(5000);
    check_state("clear");
    clear_cram();
    cram[0] = enci(I_SETI2, 1, 4);
    cram[1] = enci(I_SETI2, 2, 4);
    cram[2] = enci(I_SETI2, 3, 'h777);
    cram[3] = enci(I_SETI2, 4, 'h999);
    cram[4] = enc(I_STORER, 3, 2, 1);
    cram[5] = enc(I_STORER, 4, 2, 1);
    cram[6] = enc(I_LOADR, 5, 2, 1);
    cram[7] = {I_HALT, 26'b0};
    do_reset();
    run(20);
    chk("st_ld_dram8", dut.dram_mem[8], 32'h999);
    chk("st_ld_r5", dut.u_rf.rf_q[5], 32'h999);
    check_state("st_ld");
    clear_cram();
    cram[0] = enci(I_SETI2, 1, 'h1FFFFF);
    cram[1] = enci(I_SETI1, 1, 'h7FF);
    cram[2] = enc(I_ADD, 2, 1, 1);
    cram[3] = enci(I_SETI2, 0, 5);
    cram[4] = {I_HALT, 26'b0};
    do_reset();
    run(20);
    chk("seti_r1", dut.u_rf.rf_q[1], 32'hFFFF_FFFF);
    chk("add_wrap_r2", dut.u_rf.rf_q[2], 32'hFFFF_FFFE);
    chk("r0_zero", dut.u_rf.rf_q[0], 0);
    check_state("arith");
    clear_cram();
    cram[3] = encb(0, 0, -1);
    do_reset();
    repeat (3) step(h);
    repeat (4) begin
      step(h);
      chk("beq_self_pc", 32'(bus.cram_addr), 3);
    end
    clear_cram();
    cram[0] = encj('h405);
    cram[5] = {I_HALT, 26'b0};
    do_reset();
    step(h);
    chk("jmp_wrap_pc", 32'(bus.cram_addr), 5);
    run(10);
    clear_cram();
    cram[0] = enci(I_SETI2, 1, 'h141);
    cram[1] = enc(I_PUTC, 1, 0, 0);
    cram[2] = {I_HALT, 26'b0};
    hold = 5;
    do_reset();
    run(10);
    chk("putc_data", 32'(bus.io_o_data), 32'h41);
    clear_cram();
    cram[0] = enc(I_GETC, 2, 0, 0);
    cram[1] = {I_HALT, 26'b0};
    hold = 4;
    in_byte = 8'hA5;
    do_reset();
    run(10);
    chk("getc_r2", dut.u_rf.rf_q[2], 32'h0000_00A5);
    hold = -1;
    clear_cram();
    cram[0] = enci(I_SETI2, 1, 'h141);
    cram[1] = enc(I_PUTC, 1, 0, 0);
    cram[2] = {I_HALT, 26'b0};
    do_reset();
    step(h);
    bus.io_o_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("out_before_rst", 32'(bus.io_o_valid), 1);
    do_reset();
    run(10);
    clear_cram();
    cram[0] = enci(I_SETI2, 1, 7);
    cram[1] = enc(I_STORER, 1, 0, 1);
    cram[2] = enc(I_LOADR, 2, 0, 1);
    cram[3] = {I_HALT, 26'b0};
    do_reset();
    step(h);
    step(h);
    @(negedge clk);
    @(negedge clk);
    do_reset();
    chk("load_rst_dram7", dut.dram_mem[7], 7);
    chk("load_rst_r2", dut.u_rf.rf_q[2], 0);
    run(10);
    check_state("load_rst");
    for (int p = 0; p < 4; p++) begin
      clear_cram();
      for (int i = 0; i < 48; i++) cram[i] = rand_ins();
      do_reset();
      h = 1'b0;
      for (int s = 0; s < 250 && !h; s++) begin
        in_byte = 8'($urandom);
        step(h);
      end
      check_state("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
